// File: rtl/mycpu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   op_t    : req_op encoding presented by the EX stage
//   state_t : controller FSM states
//   DIV_ITER: restoring-divide iteration count (one quotient bit per cycle)
package mycpu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    localparam int unsigned DIV_ITER = 32;

endpackage

// File: rtl/mycpu_muldiv_ctrl_if.sv
// Request/result bundle between the EX stage and the HI/LO unit.
//   master : EX side   (drives req_valid, req_op, src_a, src_b, flush)
//   slave  : HI/LO unit (drives busy, done, hi, lo)
interface mycpu_muldiv_ctrl_if;
    import mycpu_pkg::*;

    logic        req_valid;
    op_t         req_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output req_valid, req_op, src_a, src_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  req_valid, req_op, src_a, src_b, flush,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mycpu_div_core.sv
// Restoring divider datapath, sequenced by the controller.
//   clk, reset          : clock, synchronous active-high reset
//   clear               : drop any operation in progress
//   start               : latch operand magnitudes and result signs
//   is_signed           : start belongs to DIV (not DIVU)
//   dividend, divisor   : operands, sampled on start
//   step                : one restoring iteration (one quotient bit)
//   fix                 : fold the sign correction into the registers
//   quotient, remainder : sign-corrected results (valid during fix cycle)
//   div_by_zero         : divisor of the current operation was zero
module mycpu_div_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        step,
    input  logic        fix,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        neg_q;
    logic        neg_r;
    logic        dz;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [33:0] trial;

    always_comb begin
        abs_a = (is_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
        abs_b = (is_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;
        // Extra top bit keeps the borrow visible when rem[31] shifts out.
        trial = {1'b0, rem, quo[31]} - {2'b00, dvs};
    end

    assign quotient    = neg_q ? (32'd0 - quo) : quo;
    assign remainder   = neg_r ? (32'd0 - rem) : rem;
    assign div_by_zero = dz;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
        end else if (start) begin
            rem   <= '0;
            quo   <= abs_a;
            dvs   <= abs_b;
            neg_q <= is_signed && (dividend[31] ^ divisor[31]);
            neg_r <= is_signed && dividend[31];
            dz    <= (divisor == '0);
        end else if (step) begin
            if (!trial[33]) begin
                rem <= trial[31:0];
                quo <= {quo[30:0], 1'b1};
            end else begin
                rem <= {rem[30:0], quo[31]};
                quo <= {quo[30:0], 1'b0};
            end
        end else if (fix) begin
            quo   <= quotient;
            rem   <= remainder;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end
    end

endmodule

// File: rtl/mycpu_muldiv_ctrl.sv
// HI/LO unit controller: MULT/MULTU, DIV/DIVU, MTHI/MTLO.
//   MUL_CYCLES : cycles spent in MUL (1..8)
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of the EX request/result bundle
module mycpu_muldiv_ctrl
    import mycpu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mycpu_muldiv_ctrl_if.slave   bus
);

    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LAST = 6'(DIV_ITER);

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        busy_reg;
    logic        done_reg;

    logic [63:0] prod_pipe [MUL_CYCLES];
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_prod;

    logic        accept;
    logic        is_mul_op;
    logic        is_div_op;
    logic        div_step;
    logic        div_fix;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        div_dz;

    always_comb begin
        is_mul_op = (bus.req_op == OP_MULT) || (bus.req_op == OP_MULTU);
        is_div_op = (bus.req_op == OP_DIV)  || (bus.req_op == OP_DIVU);
        accept    = bus.req_valid && !bus.flush &&
                    ((state == ST_IDLE) || (state == ST_DONE));
        // Low 64 bits of a 64x64 product of the extended operands give the
        // signed or unsigned 32x32 result depending on the extension.
        mul_a     = {{32{(bus.req_op == OP_MULT) && bus.src_a[31]}}, bus.src_a};
        mul_b     = {{32{(bus.req_op == OP_MULT) && bus.src_b[31]}}, bus.src_b};
        mul_prod  = mul_a * mul_b;
        div_step  = (state == ST_DIV) && (cnt != DIV_LAST);
        div_fix   = (state == ST_DIV) && (cnt == DIV_LAST);
    end

    // Product enters stage 0 at acceptance and shifts one stage per cycle;
    // the last stage is valid exactly when the MUL counter expires.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < MUL_CYCLES; i++) prod_pipe[i] <= '0;
        end else begin
            if (accept && is_mul_op) prod_pipe[0] <= mul_prod;
            for (int unsigned i = 1; i < MUL_CYCLES; i++) prod_pipe[i] <= prod_pipe[i-1];
        end
    end

    mycpu_div_core u_div (
        .clk         (clk),
        .reset       (reset),
        .clear       (bus.flush),
        .start       (accept && is_div_op),
        .is_signed   (bus.req_op == OP_DIV),
        .dividend    (bus.src_a),
        .divisor     (bus.src_b),
        .step        (div_step),
        .fix         (div_fix),
        .quotient    (div_q),
        .remainder   (div_r),
        .div_by_zero (div_dz)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else if (bus.flush) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    if (bus.req_valid) begin
                        case (bus.req_op)
                            OP_MTHI: begin
                                hi_reg   <= bus.src_a;
                                state    <= ST_DONE;
                                done_reg <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_reg   <= bus.src_a;
                                state    <= ST_DONE;
                                done_reg <= 1'b1;
                            end
                            OP_MULT, OP_MULTU: begin
                                state    <= ST_MUL;
                                busy_reg <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                state    <= ST_DIV;
                                busy_reg <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt == MUL_LAST) begin
                        {hi_reg, lo_reg} <= prod_pipe[MUL_CYCLES-1];
                        state    <= ST_DONE;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                ST_DIV: begin
                    if (cnt == DIV_LAST) begin
                        if (!div_dz) begin
                            hi_reg <= div_r;
                            lo_reg <= div_q;
                        end
                        state    <= ST_DONE;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_mycpu_muldiv_ctrl.sv
module tb_mycpu_muldiv_ctrl;
    import mycpu_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mycpu_muldiv_ctrl_if bus();

    mycpu_muldiv_ctrl #(.MUL_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        op_t         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Present one request for one edge, then count edges until done (bounded).
    // Returns #1 after the edge that raised done.
    task automatic run_op(input op_t op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        bus.req_op    = op;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int done_seen;

        total = 0;
        bad   = 0;
        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 2};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 2};
        vecs[2]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 2};
        vecs[3]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 2};
        vecs[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[6]  = '{OP_DIVU,  32'd100,      32'h00000000, 32'h00000000, 32'h80000000, 33};
        vecs[7]  = '{OP_DIVU,  32'd1000,     32'd7,        32'h00000006, 32'h0000008E, 33};
        vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, 33};
        vecs[10] = '{OP_DIV,   32'h00000000, 32'd5,        32'h00000000, 32'h00000000, 33};
        vecs[11] = '{OP_MTHI,  32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 0};
        vecs[12] = '{OP_MTLO,  32'h87654321, 32'h00000000, 32'hDEADBEEF, 32'h87654321, 0};

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_MULT;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat));
            chk($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_one_cycle", i), {31'd0, bus.done}, 32'd0);
        end

        // DIVU 1000/7 with an ignored request mid-op, then flush at counter 10.
        bus.req_op = OP_DIVU; bus.src_a = 32'd1000; bus.src_b = 32'd7;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.req_op = OP_MTHI; bus.src_a = 32'h55555555; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("div_busy_mid", {31'd0, bus.busy}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_done", {31'd0, bus.done}, 32'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done || bus.busy) done_seen++;
            @(posedge clk); #1;
        end
        chk("flush_no_done_later", 32'(done_seen), 32'd0);
        chk("flush_hi_kept", bus.hi, 32'hDEADBEEF);
        chk("flush_lo_kept", bus.lo, 32'h87654321);
        bus.req_op = OP_MTLO; bus.src_a = 32'h12345678; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("mtlo_done", {31'd0, bus.done}, 32'd1);
        chk("mtlo_lo", bus.lo, 32'h12345678);
        chk("mtlo_hi", bus.hi, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Reset mid-DIV, then MTHI squashed by a same-cycle flush.
        bus.req_op = OP_DIV; bus.src_a = 32'd100; bus.src_b = 32'd3; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
        chk("midreset_done", {31'd0, bus.done}, 32'd0);
        chk("midreset_hi", bus.hi, 32'd0);
        chk("midreset_lo", bus.lo, 32'd0);
        bus.req_op = OP_MTHI; bus.src_a = 32'hA5A5A5A5; bus.req_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.flush = 1'b0;
        chk("flushed_mthi_hi", bus.hi, 32'd0);
        chk("flushed_mthi_done", {31'd0, bus.done}, 32'd0);
        @(posedge clk); #1;
        chk("flushed_mthi_done_later", {31'd0, bus.done}, 32'd0);

        // Back-to-back: MULT accepted in the DONE cycle of DIVU.
        run_op(OP_DIVU, 32'd1000, 32'd7, lat, bcnt);
        chk("b2b_div_latency", 32'(lat), 32'd33);
        chk("b2b_div_lo", bus.lo, 32'h0000008E);
        chk("b2b_div_hi", bus.hi, 32'h00000006);
        run_op(OP_MULT, 32'hFFFFFFFB, 32'd3, lat, bcnt);
        chk("b2b_mul_latency", 32'(lat), 32'd2);
        chk("b2b_mul_busy_cycles", 32'(bcnt), 32'd2);
        chk("b2b_mul_hi", bus.hi, 32'hFFFFFFFF);
        chk("b2b_mul_lo", bus.lo, 32'hFFFFFFF1);
        @(posedge clk); #1;
        chk("b2b_idle_done", {31'd0, bus.done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mycpu_muldiv_ctrl.md
MYCPU_MULDIV_CTRL -- requirements
Module: mycpu_muldiv_ctrl

Interface
REQ-001 Parameter: MUL_CYCLES, default 2, cycles the MUL state occupies (legal range 1..8).
REQ-002 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: req_valid  in  1  EX stage presents a HI/LO-class instruction this cycle.
REQ-005 Port: req_op  in  3  MULT, MULTU, DIV, DIVU, MTHI or MTLO, encoded per the shared package.
REQ-006 Port: src_a  in  32  rs value: dividend or multiplicand, or MTHI/MTLO data.
REQ-007 Port: src_b  in  32  rt value: divisor or multiplier.
REQ-008 Port: flush  in  1  exception/eret flush from the pipeline.
REQ-009 Port: busy  out  1  operation in flight; EX stalls while high.
REQ-010 Port: done  out  1  one-cycle completion pulse.
REQ-011 Port: hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-012 FSM states: IDLE, MUL, DIV, DONE; busy=1 exactly in MUL and DIV; done=1 exactly in DONE.
REQ-013 Request accepted at edge E0 only when req_valid=1, flush=0 and state is IDLE or DONE; otherwise ignored (EX holds it).
REQ-014 MTHI/MTLO: hi (resp. lo) := src_a at E0; next state DONE.
REQ-015 MULT/MULTU: operands latched at E0; MUL for MUL_CYCLES cycles; {hi,lo} := 64-bit signed/unsigned product at edge E(MUL_CYCLES), entering DONE.
REQ-016 DIV/DIVU: operands latched at E0; DIV for 33 cycles (32 restoring iterations + 1 sign-correction), counter 0..32; hi/lo written at E33, entering DONE.
REQ-017 Division results: lo=quotient, hi=remainder; signed quotient sign = sign(a) XOR sign(b), remainder sign = sign(a), truncation toward zero.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000.
REQ-019 Divisor zero (DIV or DIVU): no trap; full 33-cycle latency; hi/lo unchanged; done still pulses.
REQ-020 DONE lasts one cycle, then goes to IDLE unless a new request is accepted in it (back-to-back).
REQ-021 flush=1 in any state: next state IDLE, counters cleared, no hi/lo write, no done pulse; a request in the same cycle is dropped, including MTHI/MTLO.
REQ-022 hi/lo change only on the completion edges of REQ-014..REQ-016.

Reset
REQ-023 reset=1 at an edge: state IDLE, counter 0, hi=lo=0x00000000, busy=0, done=0, datapath registers cleared.
REQ-024 Reset overrides flush and req_valid; mid-operation reset discards the operation with no hi/lo write.

Structure
REQ-025 Shared package mycpu_pkg holds the req_op encoding (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5), the FSM state enum, and DIV_ITER=32.
REQ-026 Divide datapath in sub-module mycpu_div_core: start/step/fix controls from the controller; holds partial remainder, quotient and operand signs.
REQ-027 Multiplier is an inline pipelined product register chain of depth MUL_CYCLES inside the controller.

Verification
REQ-028 MULTU 0xFFFFFFFF x 0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE, done 1 cycle after E2 (MUL_CYCLES=2); MULT same operands -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-029 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, busy for 33 cycles, done in cycle after E33.
REQ-030 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; then DIVU 100 / 0 -> hi/lo unchanged, done after 33 cycles.
REQ-031 DIVU 1000/7 with flush at counter 10 -> IDLE next cycle, busy=0, no done, hi/lo unchanged; MTLO 0x12345678 the next cycle -> lo=0x12345678, done next cycle.
REQ-032 reset asserted mid-DIV -> all outputs 0 next cycle; MTHI with flush=1 in the same cycle -> hi unchanged, no done.
REQ-033 MULT accepted in the DONE cycle of a prior DIVU -> no idle gap; both results are correct in sequence.
